// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// One CW-bit chunk is added per stage; upper operand bits ride along until needed.
module cla_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cIn,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             cOut,
   output logic             ovf
);

   localparam int CW = WIDTH / STAGES;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : bad_cfg
      $error("cla_pipe_adder: WIDTH must split into STAGES equal chunks");
   end

   logic             adv;
   logic [WIDTH-1:0] bp;
   logic             c0;

   assign bp       = sub ? ~in2 : in2;
   assign c0       = sub | cIn;
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int RW = WIDTH - k * CW;
      localparam int SW = (k + 1) * CW;

      logic [RW-1:0] a_r, b_r;
      logic          c_r, v_r;
      logic [CW-1:0] g, p, sum;
      logic [CW:0]   cc;
      logic [SW-1:0] s_d, s_q;
      logic          v_q, c_q;

      if (k == 0) begin : src
         assign a_r = in1;
         assign b_r = bp;
         assign c_r = c0;
         assign v_r = in_valid;
         assign s_d = sum;
      end else begin : src
         assign a_r = stg[k-1].fwd.a_q;
         assign b_r = stg[k-1].fwd.b_q;
         assign c_r = stg[k-1].c_q;
         assign v_r = stg[k-1].v_q;
         assign s_d = {sum, stg[k-1].s_q};
      end

      // Each carry is the OR of every lower generate propagated up to it.
      always_comb begin
         logic pp;
         pp = 1'b0;
         g  = a_r[CW-1:0] & b_r[CW-1:0];
         p  = a_r[CW-1:0] ^ b_r[CW-1:0];
         cc = '0;
         cc[0] = c_r;
         for (int i = 0; i < CW; i++) begin
            cc[i+1] = g[i];
            pp      = p[i];
            for (int j = i - 1; j >= 0; j--) begin
               cc[i+1] = cc[i+1] | (g[j] & pp);
               pp      = pp & p[j];
            end
            cc[i+1] = cc[i+1] | (pp & c_r);
         end
         sum = p ^ cc[CW-1:0];
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_r;
            c_q <= cc[CW];
            s_q <= s_d;
         end
      end

      if (k < STAGES - 1) begin : fwd
         logic [RW-CW-1:0] a_q, b_q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv) begin
               a_q <= a_r[RW-1:CW];
               b_q <= b_r[RW-1:CW];
            end
         end
      end else begin : fl
         logic ovf_q;

         // Top chunk holds both operand sign bits and the result sign bit.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= (a_r[RW-1] == b_r[RW-1]) & (sum[CW-1] != a_r[RW-1]);
            end
         end
      end
   end

   assign out_valid = stg[STAGES-1].v_q;
   assign out       = stg[STAGES-1].s_q;
   assign cOut      = stg[STAGES-1].c_q;
   assign ovf       = stg[STAGES-1].fl.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed ops, stalls, resets and parameter sweeps
// against a queue-based arithmetic model.
module tb_cla_pipe_adder;

   typedef struct {
      logic [31:0] o;
      logic        c;
      logic        v;
      int          pos;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   ent_t q[3][$];

   logic        iv16, ir16, ci16, sb16, ov16, ordy16, co16, of16;
   logic [15:0] a16, b16, o16;
   logic        iv32, ir32, ci32, sb32, ov32, ordy32, co32, of32;
   logic [31:0] a32, b32, o32;
   logic        iv8, ir8, ci8, sb8, ov8, ordy8, co8, of8;
   logic [7:0]  a8, b8, o8;

   cla_pipe_adder #(.WIDTH(16), .STAGES(4)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
      .in1(a16), .in2(b16), .cIn(ci16), .sub(sb16),
      .out_valid(ov16), .out_ready(ordy16), .out(o16),
      .cOut(co16), .ovf(of16));

   cla_pipe_adder #(.WIDTH(32), .STAGES(2)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .in1(a32), .in2(b32), .cIn(ci32), .sub(sb32),
      .out_valid(ov32), .out_ready(ordy32), .out(o32),
      .cOut(co32), .ovf(of32));

   cla_pipe_adder #(.WIDTH(8), .STAGES(1)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .in1(a8), .in2(b8), .cIn(ci8), .sub(sb8),
      .out_valid(ov8), .out_ready(ordy8), .out(o8),
      .cOut(co8), .ovf(of8));

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t gold(int w, logic [31:0] a, logic [31:0] b,
                                 logic ci, logic sb);
      ent_t        e;
      logic [63:0] m, aa, bb, s;
      m      = (64'd1 << w) - 64'd1;
      aa     = {32'd0, a} & m;
      bb     = (sb ? ~{32'd0, b} : {32'd0, b}) & m;
      s      = aa + bb + 64'(sb ? 1'b1 : ci);
      e.o    = s[31:0] & m[31:0];
      e.c    = s[w];
      e.v    = (aa[w-1] == bb[w-1]) && (e.o[w-1] != aa[w-1]);
      e.pos  = 0;
      return e;
   endfunction

   // pos = advancing edges since acceptance; the head is visible at pos == st
   task automatic model(int id, int st, int w, logic iv, logic ordy,
                        logic [31:0] a, logic [31:0] b, logic ci, logic sb,
                        logic ov, logic ir, logic [31:0] o, logic co,
                        logic of);
      logic ove, advx;
      ent_t e;
      ove = (q[id].size() > 0) && (q[id][0].pos == st);
      chk($sformatf("out_valid%0d", id), 32'(ov), 32'(ove));
      chk($sformatf("in_ready%0d", id), 32'(ir), 32'(!ove || ordy));
      if (ove) begin
         chk($sformatf("out%0d", id), o, q[id][0].o);
         chk($sformatf("cOut%0d", id), 32'(co), 32'(q[id][0].c));
         chk($sformatf("ovf%0d", id), 32'(of), 32'(q[id][0].v));
      end
      advx = !ove || ordy;
      if (advx) begin
         if (ove) void'(q[id].pop_front());
         for (int i = 0; i < q[id].size(); i++)
            q[id][i].pos = q[id][i].pos + 1;
         if (iv) begin
            e     = gold(w, a, b, ci, sb);
            e.pos = 1;
            q[id].push_back(e);
         end
      end
   endtask

   task automatic step();
      #1;
      model(0, 4, 16, iv16, ordy16, 32'(a16), 32'(b16), ci16, sb16,
            ov16, ir16, 32'(o16), co16, of16);
      model(1, 2, 32, iv32, ordy32, a32, b32, ci32, sb32,
            ov32, ir32, o32, co32, of32);
      model(2, 1, 8, iv8, ordy8, 32'(a8), 32'(b8), ci8, sb8,
            ov8, ir8, 32'(o8), co8, of8);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      iv16 = 1'b0; ordy16 = 1'b1;
      iv32 = 1'b0; ordy32 = 1'b1;
      iv8  = 1'b0; ordy8  = 1'b1;
   endtask

   task automatic rnd16();
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      ci16 = 1'($urandom);
      sb16 = 1'($urandom);
   endtask

   task automatic op16(logic [15:0] a, logic [15:0] b, logic ci, logic sb,
                       logic [15:0] eo, logic ec, logic ev);
      idle();
      iv16 = 1'b1; a16 = a; b16 = b; ci16 = ci; sb16 = sb;
      step();
      iv16 = 1'b0;
      repeat (3) step();
      #1;
      chk("lat4_valid", 32'(ov16), 32'd1);
      chk("dir_out", 32'(o16), 32'(eo));
      chk("dir_cOut", 32'(co16), 32'(ec));
      chk("dir_ovf", 32'(of16), 32'(ev));
      step();
   endtask

   initial begin
      idle();
      a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
      a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0;
      a8  = '0; b8  = '0; ci8  = 1'b0; sb8  = 1'b0;

      // reset held with in_valid asserted
      iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001;
      iv32 = 1'b1; iv8 = 1'b1;
      @(negedge clk);
      repeat (2) begin
         chk("rst_valid", 32'(ov16), 32'd0);
         chk("rst_out", 32'(o16), 32'd0);
         chk("rst_cOut", 32'(co16), 32'd0);
         chk("rst_ovf", 32'(of16), 32'd0);
         chk("rst_valid32", 32'(ov32), 32'd0);
         chk("rst_valid8", 32'(ov8), 32'd0);
         @(negedge clk);
      end
      idle();
      rst = 1'b1;

      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      op16(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

      // stream, then stall with results pending
      idle();
      for (int i = 0; i < 8; i++) begin
         iv16 = 1'b1; rnd16();
         step();
      end
      ordy16 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rnd16();
         step();
      end
      idle();
      repeat (8) step();
      chk("drain16", 32'(q[0].size()), 32'd0);

      // mid-flight reset
      for (int i = 0; i < 3; i++) begin
         iv16 = 1'b1; rnd16();
         step();
      end
      idle();
      rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(ov16), 32'd0);
      for (int i = 0; i < 3; i++) q[i].delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (6) step();

      // parameter sweep with random handshakes
      for (int i = 0; i < 1000; i++) begin
         iv32   = ($urandom_range(0, 3) != 0);
         ordy32 = ($urandom_range(0, 3) != 0);
         a32 = $urandom; b32 = $urandom;
         ci32 = 1'($urandom); sb32 = 1'($urandom);
         iv8    = ($urandom_range(0, 3) != 0);
         ordy8  = ($urandom_range(0, 3) != 0);
         a8 = 8'($urandom); b8 = 8'($urandom);
         ci8 = 1'($urandom); sb8 = 1'($urandom);
         step();
      end
      idle();
      repeat (6) step();
      chk("drain32", 32'(q[1].size()), 32'd0);
      chk("drain8", 32'(q[2].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
